// File: rtl/osc_freq_monitor.sv
// Oscillator supervisor: synchronised edge strobes, windowed edge counts, sticky range failures.
// Optional per-channel stuck detection is built when OSC_MON_STUCK_DET_EN is defined.
module osc_freq_monitor #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
`ifdef OSC_MON_STUCK_DET_EN
  , parameter int STUCK_CYCLES = 1024
`endif
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [NUM_CH-1:0]       OSC_IN,
  input  logic [NUM_CH*CNT_W-1:0] MIN_CNT,
  input  logic [NUM_CH*CNT_W-1:0] MAX_CNT,
  input  logic [NUM_CH-1:0]       FAIL_CLR,
  output logic [NUM_CH-1:0]       OSC_RISE,
  output logic [NUM_CH*CNT_W-1:0] FREQ_CNT,
  output logic                    FREQ_VALID,
  output logic [NUM_CH-1:0]       OSC_FAIL,
  output logic                    FAIL_IRQ
);
  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, LATCH = 2'd2} state_e;

  logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]       hist_q;
  logic [NUM_CH-1:0]       rise_q;
  state_e                  state_q;
  logic [GATE_W-1:0]       gate_q;
  logic [NUM_CH*CNT_W-1:0] edge_q;
  logic [NUM_CH*CNT_W-1:0] edge_inc_d;
  logic [NUM_CH*CNT_W-1:0] edge_reload_d;
  logic [NUM_CH*CNT_W-1:0] freq_q;
  logic                    valid_q;
  logic [NUM_CH-1:0]       fail_q;
  logic [NUM_CH-1:0]       fail_d;
  logic [NUM_CH-1:0]       lim_fail_d;
  logic [NUM_CH-1:0]       stuck_set_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_SAT)) ? v + CNT_W'(1) : v;
  endfunction

  // Synchroniser chain, history flop and registered rising-edge strobe
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q[0] <= OSC_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  // Per-channel saturating increment, LATCH reload value and inclusive limit test
  always_comb begin
    edge_inc_d    = edge_q;
    edge_reload_d = '0;
    lim_fail_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      edge_inc_d[i*CNT_W +: CNT_W]    = sat_inc(edge_q[i*CNT_W +: CNT_W], rise_q[i]);
      edge_reload_d[i*CNT_W +: CNT_W] = CNT_W'(rise_q[i]);
      lim_fail_d[i] = (edge_q[i*CNT_W +: CNT_W] < MIN_CNT[i*CNT_W +: CNT_W]) ||
                      (edge_q[i*CNT_W +: CNT_W] > MAX_CNT[i*CNT_W +: CNT_W]);
    end
  end

  // Measurement FSM; an edge seen in LATCH opens the next window's count
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_q <= '0;
          edge_q <= '0;
          if (ENABLE) state_q <= MEASURE;
        end
        MEASURE: begin
          if (!ENABLE) begin
            state_q <= IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
          end else begin
            edge_q <= edge_inc_d;
            if (gate_q == GATE_LAST) state_q <= LATCH;
            else                     gate_q  <= gate_q + GATE_W'(1);
          end
        end
        LATCH: begin
          freq_q  <= edge_q;
          valid_q <= 1'b1;
          gate_q  <= '0;
          edge_q  <= ENABLE ? edge_reload_d : '0;
          state_q <= ENABLE ? MEASURE : IDLE;
        end
        default: begin
          state_q <= IDLE;
          gate_q  <= '0;
          edge_q  <= '0;
        end
      endcase
    end
  end

`ifdef OSC_MON_STUCK_DET_EN
  localparam int                 STUCK_W   = $clog2(STUCK_CYCLES + 1);
  localparam logic [STUCK_W-1:0] STUCK_LIM = STUCK_W'(STUCK_CYCLES);

  logic [STUCK_W-1:0] idle_q [NUM_CH];

  // Cycles since each channel's last edge, saturating at the stuck limit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) idle_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((state_q == IDLE) || rise_q[i]) idle_q[i] <= '0;
        else if (idle_q[i] != STUCK_LIM)    idle_q[i] <= idle_q[i] + STUCK_W'(1);
        else                                idle_q[i] <= idle_q[i];
      end
    end
  end

  // Flag fires on the cycle the idle count reaches the limit, not while it sits there
  always_comb begin
    stuck_set_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      stuck_set_d[i] = (state_q == MEASURE) && !rise_q[i] && (idle_q[i] == STUCK_LIM - STUCK_W'(1));
  end
`else
  assign stuck_set_d = '0;
`endif

  assign fail_d = (fail_q & ~FAIL_CLR) | ((state_q == LATCH) ? lim_fail_d : '0) | stuck_set_d;

  // Sticky failure flags; a set always beats a simultaneous clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) fail_q <= '0;
    else       fail_q <= fail_d;
  end

  assign OSC_RISE   = rise_q;
  assign FREQ_CNT   = freq_q;
  assign FREQ_VALID = valid_q;
  assign OSC_FAIL   = fail_q;
  assign FAIL_IRQ   = |fail_q;
endmodule
